// File: rtl/usb_pkg.sv
// Shared types and sizes for the USB receive-frame unpacker.
// USB_UNPACK_SUM_EN adds the trailing-checksum state to the FSM.
package usb_pkg;

  localparam int unsigned HeaderLen = 2;
  localparam int unsigned AddrW     = 12;
  localparam int unsigned ByteW     = 8;

  typedef enum logic [2:0] {
    StIdle,
    StHead0,
    StHead1,
    StData,
`ifdef USB_UNPACK_SUM_EN
    StSum,
`endif
    StDone
  } state_e;

endpackage

// File: rtl/usb_unpack_if.sv
// Frame handshake, RAM read port and payload byte stream of the unpacker.
// master: the unpacker; slave: USB core, receive RAM and byte sink.
interface usb_unpack_if;
  import usb_pkg::*;

  logic             fs_read;
  logic             fd_read;
  logic [3:0]       read_btype;
  logic [3:0]       btype;
  logic [AddrW-1:0] ram_rxa;
  logic [ByteW-1:0] ram_rxd;
  logic [ByteW-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             len_err;
  logic             sum_err;

  modport master (
    input  fs_read, read_btype, ram_rxd, dout_ready,
    output fd_read, btype, ram_rxa, dout, dout_valid, dout_last, len_err, sum_err
  );

  modport slave (
    output fs_read, read_btype, ram_rxd, dout_ready,
    input  fd_read, btype, ram_rxa, dout, dout_valid, dout_last, len_err, sum_err
  );

endinterface

// File: rtl/usb_unpack_skid.sv
// Two-entry {last, data} FIFO with registered head; absorbs the RAM read
// latency while the byte sink stalls.
module usb_unpack_skid
  import usb_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [ByteW-1:0] i_data,
  input  logic             i_last,
  input  logic             i_pop,
  output logic [ByteW-1:0] o_data,
  output logic             o_last,
  output logic             o_valid,
  output logic             o_full
);

  logic [ByteW-1:0] r_data0, r_data1;
  logic             r_last0, r_last1;
  logic             r_valid0, r_valid1;
  logic             w_pop;

  assign w_pop = i_pop && r_valid0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data0  <= '0;
      r_data1  <= '0;
      r_last0  <= 1'b0;
      r_last1  <= 1'b0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
    end else if (w_pop) begin
      if (r_valid1) begin
        r_data0 <= r_data1;
        r_last0 <= r_last1;
        if (i_push) begin
          r_data1 <= i_data;
          r_last1 <= i_last;
        end else begin
          r_valid1 <= 1'b0;
        end
      end else if (i_push) begin
        r_data0 <= i_data;
        r_last0 <= i_last;
      end else begin
        r_valid0 <= 1'b0;
        r_last0  <= 1'b0;
      end
    end else if (i_push) begin
      if (!r_valid0) begin
        r_data0  <= i_data;
        r_last0  <= i_last;
        r_valid0 <= 1'b1;
      end else begin
        r_data1  <= i_data;
        r_last1  <= i_last;
        r_valid1 <= 1'b1;
      end
    end
  end

  assign o_data  = r_data0;
  assign o_last  = r_last0;
  assign o_valid = r_valid0;
  assign o_full  = r_valid1;

endmodule

// File: rtl/usb_unpack.sv
// Walks a received frame in RAM: 12-bit length header, payload bytes out on
// valid/ready. USB_UNPACK_SUM_EN also checks a trailing 8-bit payload sum.
module usb_unpack
  import usb_pkg::*;
#(
  parameter logic [AddrW-1:0] BASE_ADDR = 12'h000,
  parameter logic [AddrW-1:0] MAX_LEN   = 12'd4000
) (
  input logic           i_clk,
  input logic           i_rst,
  usb_unpack_if.master  bus
);

  state_e           r_state, w_state_d;
  logic [AddrW-1:0] r_addr, r_cnt, r_len, w_len;
  logic [3:0]       r_len_hi, r_btype;
  logic             r_head_lo, r_pend, r_pend_last, r_fd_read, r_len_err;
  logic             w_start, w_len_bad, w_pop, w_space, w_issue, w_issue_last;
  logic [ByteW-1:0] w_dout;
  logic             w_dout_valid, w_dout_last, w_skid_full;
`ifdef USB_UNPACK_SUM_EN
  logic [ByteW-1:0] r_sum;
  logic             r_sum_rd, r_sum_err;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_d = StHead0;
      StHead0: w_state_d = StHead1;
      StHead1: w_state_d = StData;
      StData: begin
        if (w_len_bad) begin
          w_state_d = StDone;
        end else if (w_pop && w_dout_last) begin
`ifdef USB_UNPACK_SUM_EN
          w_state_d = StSum;
`else
          w_state_d = StDone;
`endif
        end
      end
`ifdef USB_UNPACK_SUM_EN
      StSum:   if (r_sum_rd) w_state_d = StDone;
`endif
      StDone:  if (!bus.fs_read) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // The low length byte is still on ram_rxd during the first DATA cycle.
  always_comb begin
    w_start      = (r_state == StIdle) && bus.fs_read && !r_fd_read;
    w_len        = r_head_lo ? {r_len_hi, bus.ram_rxd} : r_len;
    w_len_bad    = r_head_lo && ((w_len == '0) || (w_len > MAX_LEN));
    w_pop        = w_dout_valid && bus.dout_ready;
    // Issue only if the skid still has a slot when this read returns.
    w_space      = (2'(w_dout_valid) + 2'(w_skid_full) + 2'(r_pend)) <= (2'(w_pop) + 2'd1);
    w_issue      = (r_state == StData) && !w_len_bad && (r_cnt < w_len) && w_space;
    w_issue_last = (r_cnt == (w_len - AddrW'(1)));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= BASE_ADDR;
      r_cnt       <= '0;
      r_len       <= '0;
      r_len_hi    <= '0;
      r_btype     <= '0;
      r_head_lo   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_fd_read   <= 1'b0;
      r_len_err   <= 1'b0;
`ifdef USB_UNPACK_SUM_EN
      r_sum       <= '0;
      r_sum_rd    <= 1'b0;
      r_sum_err   <= 1'b0;
`endif
    end else begin
      r_fd_read   <= (w_state_d == StDone);
      r_pend      <= w_issue;
      r_pend_last <= w_issue && w_issue_last;
      r_head_lo   <= (r_state == StHead1);
      case (r_state)
        StIdle: begin
          r_addr <= BASE_ADDR;
          r_cnt  <= '0;
          if (w_start) begin
            r_btype   <= bus.read_btype;
            r_len_err <= 1'b0;
`ifdef USB_UNPACK_SUM_EN
            r_sum     <= '0;
            r_sum_err <= 1'b0;
`endif
          end
        end
        StHead0: r_addr <= r_addr + AddrW'(1);
        StHead1: begin
          r_len_hi <= bus.ram_rxd[3:0];
          r_addr   <= BASE_ADDR + AddrW'(HeaderLen);
        end
        StData: begin
          if (r_head_lo) begin
            r_len     <= w_len;
            r_len_err <= w_len_bad;
          end
          if (w_issue) begin
            r_addr <= r_addr + AddrW'(1);
            r_cnt  <= r_cnt + AddrW'(1);
          end
`ifdef USB_UNPACK_SUM_EN
          if (r_pend) r_sum <= r_sum + bus.ram_rxd;
`endif
        end
`ifdef USB_UNPACK_SUM_EN
        // First SUM cycle presents the sum address, second compares its data.
        StSum: begin
          r_sum_rd <= !r_sum_rd;
          if (r_sum_rd) r_sum_err <= (bus.ram_rxd != r_sum);
        end
`endif
        default: ;
      endcase
    end
  end

  usb_unpack_skid u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_pend),
    .i_data  (bus.ram_rxd),
    .i_last  (r_pend_last),
    .i_pop   (w_pop),
    .o_data  (w_dout),
    .o_last  (w_dout_last),
    .o_valid (w_dout_valid),
    .o_full  (w_skid_full)
  );

  assign bus.fd_read    = r_fd_read;
  assign bus.btype      = r_btype;
  assign bus.ram_rxa    = r_addr;
  assign bus.dout       = w_dout;
  assign bus.dout_valid = w_dout_valid;
  assign bus.dout_last  = w_dout_last;
  assign bus.len_err    = r_len_err;
`ifdef USB_UNPACK_SUM_EN
  assign bus.sum_err    = r_sum_err;
`else
  assign bus.sum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_usb_unpack.sv
// Directed bench for usb_unpack with a RAM model and a payload scoreboard.
// Expectations follow USB_UNPACK_SUM_EN when it is defined.
module tb_usb_unpack;
  import usb_pkg::*;

  localparam logic [11:0] Base = 12'hFFE;
`ifdef USB_UNPACK_SUM_EN
  localparam int FdLag = 3;
  localparam bit SumOn = 1'b1;
`else
  localparam int FdLag = 1;
  localparam bit SumOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_unpack_if bus ();

  usb_unpack #(
    .BASE_ADDR (Base),
    .MAX_LEN   (12'd4000)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [7:0] mem [4096];
  always @(posedge clk) bus.ram_rxd <= mem[bus.ram_rxa];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [8:0] sb [$];
  int first_valid_cyc = -1;
  int last_hs_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted byte must match the next expected {last, data}.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (!rst && bus.dout_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.dout_ready) begin
        if (sb.size() == 0) begin
          check("extra_byte", 32'(sb.size()), 32'd1);
        end else begin
          exp = sb.pop_front();
          check("dout", 32'({bus.dout_last, bus.dout}), 32'(exp));
          if (bus.dout_last) last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic load_frame(input logic [11:0] len, input int n, input logic [7:0] seed,
                            input logic [7:0] step, input logic [7:0] sum_adj);
    logic [11:0] a;
    logic [7:0]  b, s;
    a = Base;
    s = 8'd0;
    mem[a] = {4'hA, len[11:8]};
    a = a + 12'd1;
    mem[a] = len[7:0];
    a = a + 12'd1;
    for (int i = 0; i < n; i++) begin
      b = seed + 8'(i) * step;
      mem[a] = b;
      s = s + b;
      sb.push_back({(i == n - 1), b});
      a = a + 12'd1;
    end
    mem[a] = s + sum_adj;
  endtask

  task automatic run_frame(input string tag, input logic [3:0] bt, input logic [3:0] rdy_pat,
                           input bit drop_early, input bit exp_len_err, input bit exp_sum_err,
                           input int exp_fd_k);
    int start;
    bit seen;
    first_valid_cyc = -1;
    last_hs_cyc = -1;
    bus.fs_read = 1'b1;
    bus.read_btype = bt;
    bus.dout_ready = rdy_pat[0];
    start = cyc;
    seen = 1'b0;
    for (int k = 1; k <= 6000 && !seen; k++) begin
      tick();
      bus.read_btype = ~bt;
      if (drop_early && k == 3) bus.fs_read = 1'b0;
      bus.dout_ready = rdy_pat[k % 4];
      if (bus.fd_read) seen = 1'b1;
    end
    check({tag, "_fd_read"}, 32'(bus.fd_read), 32'd1);
    check({tag, "_len_err"}, 32'(bus.len_err), 32'(exp_len_err));
    check({tag, "_sum_err"}, 32'(bus.sum_err), 32'(exp_sum_err));
    check({tag, "_btype"}, 32'(bus.btype), 32'(bt));
    check({tag, "_pending"}, 32'(sb.size()), 32'd0);
    check({tag, "_valid_done"}, 32'(bus.dout_valid), 32'd0);
    if (exp_len_err) begin
      check({tag, "_no_valid"}, 32'(first_valid_cyc), 32'hFFFF_FFFF);
      check({tag, "_fd_cycle"}, 32'(cyc - start), 32'd4);
    end else begin
      check({tag, "_fd_lag"}, 32'(cyc - last_hs_cyc), 32'(FdLag));
    end
    if (exp_fd_k > 0) begin
      check({tag, "_first_valid"}, 32'(first_valid_cyc - start), 32'd5);
      check({tag, "_fd_cycle"}, 32'(cyc - start), 32'(exp_fd_k));
    end
    bus.fs_read = 1'b0;
    bus.dout_ready = 1'b1;
    tick();
    check({tag, "_fd_release"}, 32'(bus.fd_read), 32'd0);
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_fd_read"}, 32'(bus.fd_read), 32'd0);
    check({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'd0);
    check({tag, "_dout_last"}, 32'(bus.dout_last), 32'd0);
    check({tag, "_dout"}, 32'(bus.dout), 32'd0);
    check({tag, "_ram_rxa"}, 32'(bus.ram_rxa), 32'(Base));
    check({tag, "_btype"}, 32'(bus.btype), 32'd0);
    check({tag, "_len_err"}, 32'(bus.len_err), 32'd0);
    check({tag, "_sum_err"}, 32'(bus.sum_err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    rst = 1'b1;
    bus.fs_read = 1'b0;
    bus.read_btype = 4'h0;
    bus.dout_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_state("reset");

    // 11 22 33 with the sink always ready; header upper nibble is junk.
    load_frame(12'd3, 3, 8'h11, 8'h11, 8'h00);
    run_frame("basic", 4'h5, 4'b1111, 1'b0, 1'b0, 1'b0, 7 + FdLag);

    // Same frame, ready 1,0,0,1,...; fs_read dropped early must be ignored.
    load_frame(12'd3, 3, 8'h11, 8'h11, 8'h00);
    run_frame("stall", 4'h6, 4'b1001, 1'b1, 1'b0, 1'b0, 0);

    load_frame(12'd0, 0, 8'h00, 8'h00, 8'h00);
    run_frame("len0", 4'h7, 4'b1111, 1'b0, 1'b1, 1'b0, 0);

    load_frame(12'd4001, 0, 8'h00, 8'h00, 8'h00);
    run_frame("len_over", 4'h8, 4'b1111, 1'b0, 1'b1, 1'b0, 0);

    load_frame(12'd3, 3, 8'h01, 8'h01, 8'h00);
    run_frame("sum_ok", 4'h9, 4'b1111, 1'b0, 1'b0, 1'b0, 0);

    load_frame(12'd3, 3, 8'h01, 8'h01, 8'h01);
    run_frame("sum_bad", 4'hA, 4'b1111, 1'b0, 1'b0, SumOn, 0);

    // Header at FFE/FFF, payload wraps to 000..003.
    load_frame(12'd4, 4, 8'hA0, 8'h07, 8'h00);
    run_frame("wrap", 4'hB, 4'b1111, 1'b0, 1'b0, 1'b0, 0);

    load_frame(12'd1, 1, 8'h5A, 8'h01, 8'h00);
    run_frame("len1", 4'hC, 4'b0101, 1'b0, 1'b0, 1'b0, 0);

    load_frame(12'd4000, 4000, 8'h03, 8'h01, 8'h00);
    run_frame("len_max", 4'hD, 4'b1111, 1'b0, 1'b0, 1'b0, 0);

    // Reset in the middle of DATA, then a clean frame.
    load_frame(12'd8, 8, 8'h40, 8'h03, 8'h00);
    bus.fs_read = 1'b1;
    bus.read_btype = 4'hE;
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    bus.fs_read = 1'b0;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    sb.delete();
    tick();

    load_frame(12'd3, 3, 8'h11, 8'h11, 8'h00);
    run_frame("after_rst", 4'h3, 4'b1111, 1'b0, 1'b0, 1'b0, 7 + FdLag);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
